uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, serial data bits per frame, equal to the system controller's RX frame width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port CLK, input, 1: oversampling clock; all flops rise-edge.
REQ-004 Port RST, input, 1: asynchronous active-high reset.
REQ-005 Port RX_IN, input, 1: asynchronous serial line, idle high, LSB first.
REQ-006 Port Prescale, input, 6: oversampling ratio; legal values 8, 16, 32.
REQ-007 Port PAR_EN, input, 1: 1 = parity bit present.
REQ-008 Port PAR_TYP, input, 1: 0 = even, 1 = odd.
REQ-009 Port P_DATA, output, DATA_WIDTH: received word; drives RX_P_DATA of the system controller.
REQ-010 Port Data_valid, output, 1: one-cycle strobe with P_DATA; drives RX_D_VLD.
REQ-011 Port Par_err, output, 1: one-cycle strobe on parity mismatch.
REQ-012 Port Stp_err, output, 1: one-cycle strobe when the stop bit samples low.

Function
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START SHALL occur on the first cycle the synchronized line is 0; edge counter = 0 in that cycle.
REQ-016 Prescale, PAR_EN and PAR_TYP SHALL be latched on IDLE->START and held constant for the frame; an illegal Prescale SHALL be treated as 8.
REQ-017 The edge counter SHALL count 0..P-1 per bit period and wrap to 0; the bit counter SHALL advance on each wrap.
REQ-018 Each bit SHALL be sampled at edge counts P/2-1, P/2, P/2+1 and resolved by 2-of-3 majority.
REQ-019 A START bit resolving to 1 SHALL be treated as a glitch: return to IDLE with no strobe asserted.
REQ-020 DATA SHALL shift in DATA_WIDTH bits LSB first, then go to PARITY if PAR_EN=1, else to STOP.
REQ-021 PARITY SHALL compare the received bit against the XOR of the data, inverted when PAR_TYP=1.
REQ-022 In STOP, after the majority sample at P/2+1, the FSM SHALL return to IDLE in the next cycle, without waiting for the bit end, so back-to-back frames are caught.
REQ-023 Strobes SHALL be registered and asserted in the cycle after the stop-bit sample: Data_valid=1 only if neither error is set; Par_err/Stp_err set independently; all strobes SHALL be high for exactly one cycle.
REQ-024 P_DATA SHALL update only with Data_valid and hold its value otherwise, including through errored frames.
REQ-025 Latency SHALL be: RX_IN falling at cycle T gives a strobe at T+2+(N-1)*P+P/2+2, where N = DATA_WIDTH+2+PAR_EN bits per frame.
REQ-026 A line held low through STOP SHALL raise Stp_err, and the FSM SHALL then restart only on a fresh 1->0 transition.

Reset
REQ-027 While RST=1: FSM=IDLE, counters=0, synchronizer flops=1, P_DATA=0, Data_valid=0, Par_err=0, Stp_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no strobe; after deassertion the block SHALL wait for the next falling edge.

Structure
REQ-029 Package uart_rx_pkg SHALL hold the FSM state encoding, legal prescale constants (8/16/32), and the default DATA_WIDTH.
REQ-030 Sub-module uart_rx_sampler SHALL contain the edge counter and 3-sample majority vote; the FSM, shift register, parity and strobes SHALL stay in UART_RX.

Verification
REQ-031 P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> Data_valid pulse at T+88, P_DATA=0xA5, no errors.
REQ-032 P=16, PAR_EN=0, two back-to-back frames 0x3C then 0xFF with no idle gap -> two Data_valid pulses, 0x3C then 0xFF.
REQ-033 P=8, PAR_EN=1, PAR_TYP=1, frame 0x01 with parity bit 1 -> Par_err pulse, Data_valid=0, P_DATA keeps previous value.
REQ-034 P=32, frame 0x55 with stop bit forced 0 -> Stp_err pulse, no Data_valid; a subsequent good frame 0x12 is received.
REQ-035 P=8, RX_IN low for 3 cycles then high -> no strobes, FSM back to IDLE.
REQ-036 P=8, RST pulsed in the middle of DATA -> all outputs 0, no strobe, next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // IDLE: line idle | START: start bit | DATA: payload | PARITY: parity bit | STOP: stop bit
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 2-of-3 majority vote around the bit centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_rx,
  input  logic [5:0] i_prescale,
  output logic       o_wrap,
  output logic       o_maj,
  output logic       o_maj_vld
);

  logic [5:0] r_cnt;
  logic       r_s0;
  logic       r_s1;
  logic [5:0] w_half;

  assign w_half    = {1'b0, i_prescale[5:1]};
  assign o_wrap    = (r_cnt == i_prescale - 6'd1);
  assign o_maj_vld = (r_cnt == w_half + 6'd1);
  // third vote is the live line, so the result is ready in the P/2+1 cycle itself
  assign o_maj     = majority3(r_s0, r_s1, i_rx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else begin
      if (!i_run || o_wrap) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 6'd1;
      if (r_cnt == w_half - 6'd1) r_s0 <= i_rx;
      if (r_cnt == w_half)        r_s1 <= i_rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity check and strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_par_bit;
  logic                  r_wait_high;
  logic                  r_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_start;
  logic w_run;
  logic w_wrap;
  logic w_maj;
  logic w_maj_vld;
  logic w_last_bit;
  logic w_par_bad;
  logic w_stop_sample;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  // after a stop error the line must go high again before a new start is accepted
  assign w_start       = (r_state == ST_IDLE) && !r_wait_high && !r_sync2;
  assign w_run         = (w_next != ST_IDLE);
  assign w_last_bit    = (r_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_par_bad     = r_par_en && (r_par_bit != (r_par_typ ^ (^r_shift)));
  assign w_stop_sample = (r_state == ST_STOP) && w_maj_vld;

  uart_rx_sampler u_sampler (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_run      (w_run),
    .i_rx       (r_sync2),
    .i_prescale (r_prescale),
    .o_wrap     (w_wrap),
    .o_maj      (w_maj),
    .o_maj_vld  (w_maj_vld)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_START;
      ST_START: begin
        if (w_maj_vld && w_maj) w_next = ST_IDLE;
        else if (w_wrap)        w_next = ST_DATA;
      end
      ST_DATA:   if (w_wrap && w_last_bit) w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_wrap) w_next = ST_STOP;
      ST_STOP:   if (w_maj_vld) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale  <= PRESCALE_8;
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_bit   <= 1'b0;
      r_wait_high <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_stp_err   <= 1'b0;
      r_data      <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      if (w_start) begin
        r_prescale <= legal_prescale(Prescale);
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_bit_cnt  <= '0;
      end
      if (r_state == ST_DATA && w_maj_vld) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
      if (r_state == ST_DATA && w_wrap)    r_bit_cnt <= r_bit_cnt + BW'(1);
      if (r_state == ST_PARITY && w_maj_vld) r_par_bit <= w_maj;
      if (r_state == ST_IDLE && r_sync2) r_wait_high <= 1'b0;
      if (w_stop_sample) begin
        r_par_err <= w_par_bad;
        r_stp_err <= !w_maj;
        r_valid   <= !w_par_bad && w_maj;
        if (!w_maj) r_wait_high <= 1'b1;
        if (!w_par_bad && w_maj) r_data <= r_shift;
      end
    end
  end

  assign P_DATA     = r_data;
  assign Data_valid = r_valid;
  assign Par_err    = r_par_err;
  assign Stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Frame-level bench for uart_rx: table of frames plus hand-built line corner cases.
module tb_uart_rx;

  typedef struct {
    logic [5:0] presc;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         idle;
    logic       ev;
    logic       ep;
    logic       es;
  } vec_t;

  typedef struct {
    logic       v;
    logic       p;
    logic       s;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Par_err;
  logic       Stp_err;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_strobes = 0;
  logic [7:0] model_pdata = 8'h00;
  exp_t       sb_q[$];
  exp_t       cur;
  vec_t       vecs[10];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .Par_err    (Par_err),
    .Stp_err    (Stp_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // holds the line for a number of cycles; always ends 1ns after a rising edge
  task automatic drive_bit(input logic val, input int cycles);
    if (cycles == 0) return;
    RX_IN = val;
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [5:0] presc, input logic pe, input logic pt,
                            input logic [7:0] data, input logic pbit, input logic stop,
                            input logic ev, input logic ep, input logic es);
    int   p;
    int   n;
    exp_t e;
    p = (presc == 6'd8 || presc == 6'd16 || presc == 6'd32) ? int'(presc) : 8;
    n = 10 + int'(pe);
    Prescale = presc;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    if (ev) model_pdata = data;
    e.v    = ev;
    e.p    = ep;
    e.s    = es;
    e.data = model_pdata;
    e.due  = cyc + 2 + (n - 1) * p + p / 2 + 2;
    sb_q.push_back(e);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(stop, p);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("drain_pending", sb_q.size(), 0);
    sb_q.delete();
  endtask

  always @(negedge CLK) begin
    if (!RST && (Data_valid || Par_err || Stp_err)) begin
      n_strobes++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual v/p/s=%0b%0b%0b at cyc %0d required=no strobe",
                 Data_valid, Par_err, Stp_err, cyc);
      end else begin
        cur = sb_q.pop_front();
        chk("data_valid", 32'(Data_valid), 32'(cur.v));
        chk("par_err", 32'(Par_err), 32'(cur.p));
        chk("stp_err", 32'(Stp_err), 32'(cur.s));
        chk("p_data", 32'(P_DATA), 32'(cur.data));
        chk("strobe_cycle", cyc, cur.due);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    //          presc  pe    pt    data   pbit  stop idle ev    ep    es
    vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6'd16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{6'd32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{6'd32, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{6'd16, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{6'd6,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{6'd8,  1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{6'd8,  1'b1, 1'b0, 8'h6B, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_p_data", 32'(P_DATA), 32'h0);
    chk("rst_data_valid", 32'(Data_valid), 32'h0);
    chk("rst_par_err", 32'(Par_err), 32'h0);
    chk("rst_stp_err", 32'(Stp_err), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive_bit(1'b1, 4);

    for (int i = 0; i < 10; i++) begin
      drive_bit(1'b1, vecs[i].idle);
      send_frame(vecs[i].presc, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].pbit,
                 vecs[i].stop, vecs[i].ev, vecs[i].ep, vecs[i].es);
    end
    drive_bit(1'b1, 4);
    wait_drain(2000);

    // short low pulse on an idle line must be rejected as a glitch
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    s0 = n_strobes;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);
    chk("glitch_strobes", n_strobes - s0, 0);
    send_frame(6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 4);
    wait_drain(400);

    // line stuck low through and past the stop bit: one stop error, no phantom frame
    s0 = n_strobes;
    send_frame(6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 120);
    chk("held_low_strobes", n_strobes - s0, 1);
    send_frame(6'd8, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 4);
    wait_drain(400);

    // reset in the middle of the data bits
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 16);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_p_data", 32'(P_DATA), 32'h0);
    chk("midrst_data_valid", 32'(Data_valid), 32'h0);
    chk("midrst_par_err", 32'(Par_err), 32'h0);
    chk("midrst_stp_err", 32'(Stp_err), 32'h0);
    model_pdata = 8'h00;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive_bit(1'b1, 6);
    send_frame(6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 10);
    wait_drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
